input_conditioner: RTL

- Sits between the raw player button pins and game_logic, replacing the direct `{3'b000,~pX_inputs[1:0]}` feed.
- Synchronises, inverts and debounces all 5 active-low buttons per player.
- Samples the debounced state once per frame, at the vsync falling edge, so game_logic sees values that stay stable for the whole frame.
- Also produces per-frame "newly pressed" edge flags.
- Runs entirely on the pixel clock `clk`.

---
 rtl/input_conditioner.sv | 95 +++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Synchronise, debounce and frame-latch active-low player buttons for game_logic.
// Latency: raw edge -> stb in 2+DEBOUNCE_CYCLES clk; stb -> held/pressed at next vsync fall +1 clk.
// Backpressure: none; free-running per-cycle pipeline, outputs always valid.
module input_conditioner #(
    parameter int NUM_BUTTONS     = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] p1_raw,
    input  logic [NUM_BUTTONS-1:0] p2_raw,
    input  logic                   vsync,
    output logic [NUM_BUTTONS-1:0] p1_held,
    output logic [NUM_BUTTONS-1:0] p2_held,
    output logic [NUM_BUTTONS-1:0] p1_pressed,
    output logic [NUM_BUTTONS-1:0] p2_pressed,
    output logic                   frame_tick
);

    localparam int                   NUM_BITS = 2 * NUM_BUTTONS;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Both players share one vector: player 1 in the low half, player 2 in the high half.
    logic [NUM_BITS-1:0] raw_meta;
    logic [NUM_BITS-1:0] raw_sync;
    logic [NUM_BITS-1:0] sync_act;
    logic [NUM_BITS-1:0] stb;

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_meta <= '1;
            raw_sync <= '1;
        end else begin
            raw_meta <= {p2_raw, p1_raw};
            raw_sync <= raw_meta;
        end
    end

    assign sync_act = ~raw_sync;

    // A bit is only accepted after it disagrees with stb for DEBOUNCE_CYCLES straight cycles.
    for (genvar g = 0; g < NUM_BITS; g++) begin : g_deb
        logic                 stb_q;
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                stb_q <= 1'b0;
                cnt_q <= '0;
            end else if (sync_act[g] == stb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stb_q <= sync_act[g];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stb[g] = stb_q;
    end

    logic                vsync_d;
    logic                boundary;
    logic [NUM_BITS-1:0] held_q;
    logic [NUM_BITS-1:0] pressed_q;
    logic                tick_q;

    assign boundary = vsync_d & ~vsync;

    // held_q on the right of the pressed update is the previous frame's value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d   <= 1'b1;
            held_q    <= '0;
            pressed_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            vsync_d <= vsync;
            tick_q  <= boundary;
            if (boundary) begin
                pressed_q <= stb & ~held_q;
                held_q    <= stb;
            end
        end
    end

    assign p1_held    = held_q[NUM_BUTTONS-1:0];
    assign p2_held    = held_q[NUM_BITS-1:NUM_BUTTONS];
    assign p1_pressed = pressed_q[NUM_BUTTONS-1:0];
    assign p2_pressed = pressed_q[NUM_BITS-1:NUM_BUTTONS];
    assign frame_tick = tick_q;

endmodule
